// File: rtl/pe_ctrl_gen.sv
// rtl/pe_ctrl_gen.sv - per-cycle PE control word sequencer for one layer tile
module pe_ctrl_gen #(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int ACC_CNT_WIDTH     = 8,
  parameter int PASS_CNT_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [ACC_CNT_WIDTH-1:0]           cfg_num_acc_m1,
  input  logic [PE_BUF_ADDR_WIDTH-1:0]       cfg_num_out_m1,
  input  logic [PASS_CNT_WIDTH-1:0]          cfg_num_pass_m1,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [8+2*PE_BUF_ADDR_WIDTH-1:0]   ctrl,
  output logic                               done
);

  localparam int CTRL_WIDTH = 8 + 2*PE_BUF_ADDR_WIDTH;
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_MACC = 3'd1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t                         state;
  logic [ACC_CNT_WIDTH-1:0]       num_acc_m1;
  logic [PE_BUF_ADDR_WIDTH-1:0]   num_out_m1;
  logic [PASS_CNT_WIDTH-1:0]      num_pass_m1;
  logic [ACC_CNT_WIDTH-1:0]       acc_cnt;
  logic [PE_BUF_ADDR_WIDTH-1:0]   out_cnt;
  logic [PASS_CNT_WIDTH-1:0]      pass_cnt;

  logic first_term;
  logic first_rd;
  logic last_pass;

  assign cfg_ready  = (state == IDLE);
  assign in_ready   = (state == ACCUM);
  assign first_term = (acc_cnt == '0);
  // Passes after the first resume from the partial sum stored in the buffer.
  assign first_rd   = first_term && (pass_cnt != '0);
  assign last_pass  = (pass_cnt == num_pass_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      num_acc_m1  <= '0;
      num_out_m1  <= '0;
      num_pass_m1 <= '0;
      acc_cnt     <= '0;
      out_cnt     <= '0;
      pass_cnt    <= '0;
      ctrl        <= '0;
      done        <= 1'b0;
    end else begin
      ctrl <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            num_acc_m1  <= cfg_num_acc_m1;
            num_out_m1  <= cfg_num_out_m1;
            num_pass_m1 <= cfg_num_pass_m1;
            acc_cnt     <= '0;
            out_cnt     <= '0;
            pass_cnt    <= '0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            ctrl <= {(first_rd ? out_cnt : {PE_BUF_ADDR_WIDTH{1'b0}}),
                     {PE_BUF_ADDR_WIDTH{1'b0}},
                     1'b0, 1'b0, 1'b0, first_rd, 1'b1,
                     (first_term ? OP_MUL : OP_MACC)};
            if (acc_cnt == num_acc_m1) begin
              acc_cnt <= '0;
              state   <= FLUSH;
            end else begin
              acc_cnt <= acc_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Intermediate passes park the partial sum; the last pass emits it.
          ctrl <= {{PE_BUF_ADDR_WIDTH{1'b0}}, out_cnt,
                   1'b1, last_pass, !last_pass, 1'b0, 1'b0, OP_MUL};
          if (out_cnt < num_out_m1) begin
            out_cnt <= out_cnt + 1'b1;
            state   <= ACCUM;
          end else begin
            out_cnt <= '0;
            if (pass_cnt < num_pass_m1) begin
              pass_cnt <= pass_cnt + 1'b1;
              state    <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_ctrl_gen.sv
// tb/tb_pe_ctrl_gen.sv - directed self-checking bench for pe_ctrl_gen
module tb_pe_ctrl_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_num_acc_m1;
  logic [9:0]  cfg_num_out_m1;
  logic [7:0]  cfg_num_pass_m1;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] ctrl;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [27:0] exp_ctrl;

  pe_ctrl_gen dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_num_acc_m1(cfg_num_acc_m1), .cfg_num_out_m1(cfg_num_out_m1),
    .cfg_num_pass_m1(cfg_num_pass_m1),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input logic [9:0] rd, input logic [9:0] wr,
                                     input logic fl, input logic wv, input logic wq,
                                     input logic rq, input logic en, input logic [2:0] op);
    return {rd, wr, fl, wv, wq, rq, en, op};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input logic [7:0] a, input logic [9:0] o, input logic [7:0] p);
    cfg_valid = 1'b1; cfg_num_acc_m1 = a; cfg_num_out_m1 = o; cfg_num_pass_m1 = p;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0;
    cfg_num_acc_m1 = '0; cfg_num_out_m1 = '0; cfg_num_pass_m1 = '0;
    tick; tick;
    n_tests++; if (ctrl !== 28'd0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    start_cfg(8'd2, 10'd0, 8'd0);
    n_tests++; if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy in_ready %b cfg_ready %b want 1 0", in_ready, cfg_ready); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      exp_ctrl = mk(0, 0, 0, 0, 0, 0, 1, (i == 0) ? 3'd0 : 3'd1);
      n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL basic_acc%0d got %h want %h", i, ctrl, exp_ctrl); end
    end
    in_valid = 1'b0;
    tick;
    exp_ctrl = mk(0, 0, 1, 1, 0, 0, 0, 0);
    n_tests++; if (ctrl !== exp_ctrl || done !== 1'b0) begin n_fail++; $display("FAIL basic_flush got %h done %b want %h done 0", ctrl, done, exp_ctrl); end
    tick;
    n_tests++; if (done !== 1'b1 || ctrl !== 28'd0) begin n_fail++; $display("FAIL basic_done got done %b ctrl %h want 1 0", done, ctrl); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_cfg_ready got %b want 1", cfg_ready); end
    tick;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_multi_pass;
    int ops = 0;
    start_cfg(8'd1, 10'd2, 8'd1);
    for (int p = 0; p < 2; p++) begin
      for (int o = 0; o < 3; o++) begin
        for (int a = 0; a < 2; a++) begin
          in_valid = 1'b1;
          if (in_ready) ops++;
          tick;
          exp_ctrl = mk((a == 0 && p != 0) ? 10'(o) : 10'd0, 0, 0, 0, 0,
                        (a == 0 && p != 0), 1, (a == 0) ? 3'd0 : 3'd1);
          n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL mp_acc p%0d o%0d a%0d got %h want %h", p, o, a, ctrl, exp_ctrl); end
        end
        if (in_ready) ops++;
        tick;
        exp_ctrl = mk(0, 10'(o), 1, (p == 1), (p == 0), 0, 0, 0);
        n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL mp_flush p%0d o%0d got %h want %h", p, o, ctrl, exp_ctrl); end
      end
    end
    in_valid = 1'b0;
    tick;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL mp_done got %b want 1", done); end
    n_tests++; if (ops !== 12) begin n_fail++; $display("FAIL mp_operands got %0d want 12", ops); end
    tick;
  endtask

  task automatic test_stall;
    logic        vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [27:0] epat [7];
    epat[0] = mk(0, 0, 0, 0, 0, 0, 1, 3'd0);
    epat[1] = 28'd0;
    epat[2] = 28'd0;
    epat[3] = mk(0, 0, 0, 0, 0, 0, 1, 3'd1);
    epat[4] = mk(0, 0, 0, 0, 0, 0, 1, 3'd1);
    epat[5] = mk(0, 0, 1, 1, 0, 0, 0, 0);
    epat[6] = 28'd0;
    start_cfg(8'd2, 10'd0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      tick;
      n_tests++; if (ctrl !== epat[i] || done !== (i == 6)) begin
        n_fail++; $display("FAIL stall_cyc%0d got %h done %b want %h done %b", i, ctrl, done, epat[i], (i == 6));
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    start_cfg(8'd0, 10'd0, 8'd0);
    in_valid = 1'b1;
    tick;
    exp_ctrl = mk(0, 0, 0, 0, 0, 0, 1, 3'd0);
    n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL b2b_mul got %h want %h", ctrl, exp_ctrl); end
    tick;
    exp_ctrl = mk(0, 0, 1, 1, 0, 0, 0, 0);
    n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL b2b_flush got %h want %h", ctrl, exp_ctrl); end
    tick;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got %b want 1", done); end
    start_cfg(8'd0, 10'd0, 8'd0);
    n_tests++; if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept in_ready %b cfg_ready %b want 1 0", in_ready, cfg_ready); end
    tick;
    exp_ctrl = mk(0, 0, 0, 0, 0, 0, 1, 3'd0);
    n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL b2b_mul2 got %h want %h", ctrl, exp_ctrl); end
    tick;
    tick;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %b want 1", done); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    start_cfg(8'd1, 10'd2, 8'd1);
    in_valid = 1'b1;
    tick; tick;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_flush in_ready got %b want 0", in_ready); end
    reset = 1'b1;
    tick;
    n_tests++; if (ctrl !== 28'd0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_after_reset ctrl %h done %b cfg_ready %b want 0 0 1", ctrl, done, cfg_ready);
    end
    reset = 1'b0; in_valid = 1'b0;
    tick;
    n_tests++; if (ctrl !== 28'd0 || done !== 1'b0) begin n_fail++; $display("FAIL rm_quiet ctrl %h done %b want 0 0", ctrl, done); end
    start_cfg(8'd0, 10'd1, 8'd0);
    in_valid = 1'b1;
    for (int o = 0; o < 2; o++) begin
      tick;
      exp_ctrl = mk(0, 0, 0, 0, 0, 0, 1, 3'd0);
      n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rm_mul o%0d got %h want %h", o, ctrl, exp_ctrl); end
      tick;
      exp_ctrl = mk(0, 10'(o), 1, 1, 0, 0, 0, 0);
      n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rm_flush o%0d got %h want %h", o, ctrl, exp_ctrl); end
    end
    tick;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL rm_done got %b want 1", done); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_cfg_busy;
    start_cfg(8'd1, 10'd0, 8'd0);
    cfg_valid = 1'b1; cfg_num_acc_m1 = 8'd5; cfg_num_out_m1 = 10'd3; cfg_num_pass_m1 = 8'd2;
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL busy_cfg_ready got %b want 0", cfg_ready); end
    in_valid = 1'b1;
    tick;
    exp_ctrl = mk(0, 0, 0, 0, 0, 0, 1, 3'd0);
    n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL busy_mul got %h want %h", ctrl, exp_ctrl); end
    tick;
    exp_ctrl = mk(0, 0, 0, 0, 0, 0, 1, 3'd1);
    n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL busy_macc got %h want %h", ctrl, exp_ctrl); end
    tick;
    exp_ctrl = mk(0, 0, 1, 1, 0, 0, 0, 0);
    n_tests++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL busy_flush got %h want %h", ctrl, exp_ctrl); end
    cfg_valid = 1'b0; in_valid = 1'b0;
    tick;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_done got %b want 1", done); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_multi_pass;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_cfg_busy;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
